// File: rtl/obi_latency_mem_if.sv
// obi_latency_mem_if: flat OBI A/R channel bundle.
//   master modport: drives req/addr/we/be/wdata/aid/rready, observes gnt/rvalid/rdata/rid/err
//   slave modport : the mirror image, used by obi_latency_mem
`timescale 1ns/1ps
interface obi_latency_mem_if #(
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned IdWidth   = 1
);
    logic                   req;
    logic                   gnt;
    logic [AddrWidth-1:0]   addr;
    logic                   we;
    logic [DataWidth/8-1:0] be;
    logic [DataWidth-1:0]   wdata;
    logic [IdWidth-1:0]     aid;
    logic                   rvalid;
    logic                   rready;
    logic [DataWidth-1:0]   rdata;
    logic [IdWidth-1:0]     rid;
    logic                   err;

    modport master (
        output req, addr, we, be, wdata, aid, rready,
        input  gnt, rvalid, rdata, rid, err
    );
    modport slave (
        input  req, addr, we, be, wdata, aid, rready,
        output gnt, rvalid, rdata, rid, err
    );
endinterface

// File: rtl/obi_latency_mem.sv
// obi_latency_mem: single-port OBI scratchpad memory with configurable read
// latency and a response FIFO absorbing R-channel backpressure.
//   clk_i  : clock, rising edge
//   rst_ni : asynchronous active-low reset (clears credits, pipe and FIFO, not the array)
//   bus    : obi_latency_mem_if.slave (A channel req/gnt/addr/we/be/wdata/aid,
//            R channel rvalid/rready/rdata/rid/err)
// Build option: define OBI_LATENCY_MEM_OOR_ERR_EN to answer out-of-range
// accesses with err=1 (array untouched); otherwise the word index wraps.
`timescale 1ns/1ps
module obi_latency_mem #(
    parameter int unsigned           AddrWidth    = 32,
    parameter int unsigned           DataWidth    = 32,
    parameter int unsigned           IdWidth      = 1,
    parameter int unsigned           NumWords     = 1024,
    parameter logic [AddrWidth-1:0]  BaseAddr     = '0,
    parameter int unsigned           Latency      = 1,
    parameter int unsigned           RspFifoDepth = 2
) (
    input logic              clk_i,
    input logic              rst_ni,
    obi_latency_mem_if.slave bus
);
    localparam int unsigned NumBytes  = DataWidth / 8;
    localparam int unsigned ByteShift = $clog2(NumBytes);
    localparam int unsigned IdxWidth  = $clog2(NumWords);
    localparam int unsigned CntWidth  = $clog2(RspFifoDepth + 1);
    localparam int unsigned PtrWidth  = (RspFifoDepth > 1) ? $clog2(RspFifoDepth) : 1;

    // ---------------- A channel: credits and address decode ----------------
    logic [CntWidth-1:0]  outstanding_q;
    logic                 accept;
    logic                 pop;
    logic [AddrWidth-1:0] offs;
    logic [AddrWidth-1:0] word;
    logic [IdxWidth-1:0]  idx;
    logic                 oor;

    // Credits count everything accepted and not yet handed out on R, so the
    // FIFO can never be asked to hold more than RspFifoDepth entries.
    assign bus.gnt = rst_ni & (outstanding_q < CntWidth'(RspFifoDepth));
    assign accept  = bus.req & bus.gnt;

    always_comb begin
        offs = bus.addr - BaseAddr;
        word = offs >> ByteShift;
        idx  = IdxWidth'(word);
`ifdef OBI_LATENCY_MEM_OOR_ERR_EN
        oor  = (word >= AddrWidth'(NumWords));
`else
        oor  = 1'b0;
`endif
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            outstanding_q <= '0;
        end else if (accept && !pop) begin
            outstanding_q <= outstanding_q + CntWidth'(1);
        end else if (!accept && pop) begin
            outstanding_q <= outstanding_q - CntWidth'(1);
        end
    end

    // ---------------- Array and latency pipe ----------------
    logic [DataWidth-1:0] mem    [NumWords];
    logic                 p_vld  [Latency];
    logic [IdWidth-1:0]   p_id   [Latency];
    logic                 p_err  [Latency];
    logic [DataWidth-1:0] p_data [Latency];

    // Stage 0 is the synchronous read register; the read data travels with
    // its context so later writes cannot alter an already accepted read.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            if (bus.we && !oor) begin
                for (int unsigned b = 0; b < NumBytes; b++) begin
                    if (bus.be[b]) mem[idx][b*8 +: 8] <= bus.wdata[b*8 +: 8];
                end
            end
            p_data[0] <= (bus.we || oor) ? '0 : mem[idx];
            p_id[0]   <= bus.aid;
            p_err[0]  <= oor;
        end
        for (int unsigned k = 1; k < Latency; k++) begin
            p_data[k] <= p_data[k-1];
            p_id[k]   <= p_id[k-1];
            p_err[k]  <= p_err[k-1];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned k = 0; k < Latency; k++) p_vld[k] <= 1'b0;
        end else begin
            p_vld[0] <= accept;
            for (int unsigned k = 1; k < Latency; k++) p_vld[k] <= p_vld[k-1];
        end
    end

    // ---------------- Response FIFO (fall-through when empty) ----------------
    logic [DataWidth-1:0] f_data [RspFifoDepth];
    logic [IdWidth-1:0]   f_id   [RspFifoDepth];
    logic                 f_err  [RspFifoDepth];
    logic [PtrWidth-1:0]  rd_ptr_q;
    logic [PtrWidth-1:0]  wr_ptr_q;
    logic [CntWidth-1:0]  f_cnt_q;
    logic                 in_vld;
    logic                 f_empty;
    logic                 f_full;
    logic                 rvalid;
    logic                 push;
    logic                 deq;
    logic [DataWidth-1:0] head_data;
    logic [IdWidth-1:0]   head_id;
    logic                 head_err;

    function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
        return (p == PtrWidth'(RspFifoDepth - 1)) ? '0 : p + PtrWidth'(1);
    endfunction

    assign in_vld  = p_vld[Latency-1];
    assign f_empty = (f_cnt_q == '0);
    assign f_full  = (f_cnt_q == CntWidth'(RspFifoDepth));
    assign rvalid  = !f_empty || in_vld;
    assign pop     = rvalid && bus.rready;
    // An arriving response consumed directly from the pipe is never stored.
    assign push    = in_vld && !(f_empty && pop);
    assign deq     = pop && !f_empty;

    always_comb begin
        if (f_empty) begin
            head_data = p_data[Latency-1];
            head_id   = p_id[Latency-1];
            head_err  = p_err[Latency-1];
        end else begin
            head_data = f_data[rd_ptr_q];
            head_id   = f_id[rd_ptr_q];
            head_err  = f_err[rd_ptr_q];
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            f_data[wr_ptr_q] <= p_data[Latency-1];
            f_id[wr_ptr_q]   <= p_id[Latency-1];
            f_err[wr_ptr_q]  <= p_err[Latency-1];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            f_cnt_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (deq)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            if (push && !deq)      f_cnt_q <= f_cnt_q + CntWidth'(1);
            else if (!push && deq) f_cnt_q <= f_cnt_q - CntWidth'(1);
        end
    end

    // Outputs read as zero whenever no response is presented (incl. reset).
    assign bus.rvalid = rvalid;
    assign bus.rdata  = rvalid ? head_data : '0;
    assign bus.rid    = rvalid ? head_id   : '0;
    assign bus.err    = rvalid ? head_err  : 1'b0;

    no_fifo_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni) !(push && f_full));
endmodule

// File: tb/tb_obi_latency_mem.sv
`timescale 1ns/1ps
module tb_obi_latency_mem;
    localparam int NDut = 2;
`ifdef OBI_LATENCY_MEM_OOR_ERR_EN
    localparam bit OorEn = 1'b1;
`else
    localparam bit OorEn = 1'b0;
`endif

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    // DUT A: defaults (Latency 1, depth 2, base 0). DUT B: Latency 3, depth 3, base 0x8000, 2-bit ids.
    function automatic int unsigned lat_of(input int d);   return (d == 0) ? 1 : 3; endfunction
    function automatic int unsigned depth_of(input int d); return (d == 0) ? 2 : 3; endfunction
    function automatic logic [31:0] base_of(input int d);  return (d == 0) ? 32'h0 : 32'h0000_8000; endfunction

    logic        drv_req    [NDut];
    logic        drv_we     [NDut];
    logic [31:0] drv_addr   [NDut];
    logic [3:0]  drv_be     [NDut];
    logic [31:0] drv_wdata  [NDut];
    logic [1:0]  drv_aid    [NDut];
    logic        drv_rready [NDut];

    logic        obs_gnt    [NDut];
    logic        obs_rvalid [NDut];
    logic [31:0] obs_rdata  [NDut];
    logic [1:0]  obs_rid    [NDut];
    logic        obs_err    [NDut];

    obi_latency_mem_if #(.AddrWidth(32), .DataWidth(32), .IdWidth(1)) bus_a ();
    obi_latency_mem_if #(.AddrWidth(32), .DataWidth(32), .IdWidth(2)) bus_b ();

    obi_latency_mem #(
        .AddrWidth(32), .DataWidth(32), .IdWidth(1), .NumWords(1024),
        .BaseAddr(32'h0), .Latency(1), .RspFifoDepth(2)
    ) dut_a (.clk_i(clk_i), .rst_ni(rst_ni), .bus(bus_a));

    obi_latency_mem #(
        .AddrWidth(32), .DataWidth(32), .IdWidth(2), .NumWords(1024),
        .BaseAddr(32'h0000_8000), .Latency(3), .RspFifoDepth(3)
    ) dut_b (.clk_i(clk_i), .rst_ni(rst_ni), .bus(bus_b));

    assign bus_a.req    = drv_req[0];
    assign bus_a.we     = drv_we[0];
    assign bus_a.addr   = drv_addr[0];
    assign bus_a.be     = drv_be[0];
    assign bus_a.wdata  = drv_wdata[0];
    assign bus_a.aid    = drv_aid[0][0:0];
    assign bus_a.rready = drv_rready[0];
    assign bus_b.req    = drv_req[1];
    assign bus_b.we     = drv_we[1];
    assign bus_b.addr   = drv_addr[1];
    assign bus_b.be     = drv_be[1];
    assign bus_b.wdata  = drv_wdata[1];
    assign bus_b.aid    = drv_aid[1];
    assign bus_b.rready = drv_rready[1];

    assign obs_gnt[0]    = bus_a.gnt;
    assign obs_rvalid[0] = bus_a.rvalid;
    assign obs_rdata[0]  = bus_a.rdata;
    assign obs_rid[0]    = {1'b0, bus_a.rid};
    assign obs_err[0]    = bus_a.err;
    assign obs_gnt[1]    = bus_b.gnt;
    assign obs_rvalid[1] = bus_b.rvalid;
    assign obs_rdata[1]  = bus_b.rdata;
    assign obs_rid[1]    = bus_b.rid;
    assign obs_err[1]    = bus_b.err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- Reference model ----------------
    // Each accepted request becomes one queued response that may appear from
    // cycle (accept edge + Latency - 1) on; responses leave strictly in order.
    typedef struct packed {
        logic [31:0] due;
        logic [31:0] data;
        logic [1:0]  id;
        logic        err;
    } rsp_t;

    rsp_t        mq      [NDut][8];
    int unsigned mq_head [NDut];
    int unsigned mq_cnt  [NDut];
    logic [31:0] mmem    [NDut][1024];
    int unsigned cyc = 0;

    logic        m_rv, m_acc, m_oor;
    logic [31:0] m_word;
    logic [9:0]  m_idx;
    rsp_t        m_rsp;

    initial begin
        for (int d = 0; d < NDut; d++) begin
            mq_head[d] = 0;
            mq_cnt[d]  = 0;
        end
    end

    always @(posedge clk_i) begin
        for (int d = 0; d < NDut; d++) begin
            if (!rst_ni) begin
                mq_head[d] = 0;
                mq_cnt[d]  = 0;
            end else begin
                m_rv  = (mq_cnt[d] != 0) && (mq[d][mq_head[d]].due <= cyc);
                m_acc = drv_req[d] && (mq_cnt[d] < depth_of(d));
                if (m_rv && drv_rready[d]) begin
                    mq_head[d] = (mq_head[d] + 1) % 8;
                    mq_cnt[d]  = mq_cnt[d] - 1;
                end
                if (m_acc) begin
                    m_word    = (drv_addr[d] - base_of(d)) >> 2;
                    m_oor     = OorEn && (m_word >= 32'd1024);
                    m_idx     = m_word[9:0];
                    m_rsp.due = cyc + lat_of(d);
                    m_rsp.id  = (d == 0) ? {1'b0, drv_aid[d][0]} : drv_aid[d];
                    m_rsp.err = m_oor;
                    if (drv_we[d]) begin
                        m_rsp.data = 32'h0;
                        if (!m_oor) begin
                            for (int b = 0; b < 4; b++) begin
                                if (drv_be[d][b]) mmem[d][m_idx][b*8 +: 8] = drv_wdata[d][b*8 +: 8];
                            end
                        end
                    end else begin
                        m_rsp.data = m_oor ? 32'h0 : mmem[d][m_idx];
                    end
                    mq[d][(mq_head[d] + mq_cnt[d]) % 8] = m_rsp;
                    mq_cnt[d] = mq_cnt[d] + 1;
                end
            end
        end
        cyc = cyc + 1;
    end

    // ---------------- Compare process ----------------
    logic [31:0] got_data [NDut][16];
    logic [1:0]  got_id   [NDut][16];
    logic        got_err  [NDut][16];
    int unsigned got_n    [NDut];
    int unsigned rv_cnt   [NDut];
    int unsigned rv_first [NDut];
    int unsigned rv_last  [NDut];
    int unsigned gnt_low  [NDut];
    logic        c_rv;
    rsp_t        c_head;

    always @(negedge clk_i) begin
        for (int d = 0; d < NDut; d++) begin
            if (!rst_ni) begin
                chk($sformatf("dut%0d.rst_gnt", d),    {31'h0, obs_gnt[d]},    32'h0);
                chk($sformatf("dut%0d.rst_rvalid", d), {31'h0, obs_rvalid[d]}, 32'h0);
                chk($sformatf("dut%0d.rst_rdata", d),  obs_rdata[d],           32'h0);
                chk($sformatf("dut%0d.rst_rid", d),    {30'h0, obs_rid[d]},    32'h0);
                chk($sformatf("dut%0d.rst_err", d),    {31'h0, obs_err[d]},    32'h0);
            end else begin
                c_head = mq[d][mq_head[d]];
                c_rv   = (mq_cnt[d] != 0) && (c_head.due <= cyc);
                chk($sformatf("dut%0d.gnt", d),    {31'h0, obs_gnt[d]},    {31'h0, mq_cnt[d] < depth_of(d)});
                chk($sformatf("dut%0d.rvalid", d), {31'h0, obs_rvalid[d]}, {31'h0, c_rv});
                if (c_rv) begin
                    chk($sformatf("dut%0d.rdata", d), obs_rdata[d],         c_head.data);
                    chk($sformatf("dut%0d.rid", d),   {30'h0, obs_rid[d]},  {30'h0, c_head.id});
                    chk($sformatf("dut%0d.err", d),   {31'h0, obs_err[d]},  {31'h0, c_head.err});
                end
                if (obs_rvalid[d]) begin
                    if (rv_cnt[d] == 0) rv_first[d] = cyc;
                    rv_last[d] = cyc;
                    rv_cnt[d]  = rv_cnt[d] + 1;
                end
                if (!obs_gnt[d]) gnt_low[d] = gnt_low[d] + 1;
                if (obs_rvalid[d] && drv_rready[d] && got_n[d] < 16) begin
                    got_data[d][got_n[d]] = obs_rdata[d];
                    got_id[d][got_n[d]]   = obs_rid[d];
                    got_err[d][got_n[d]]  = obs_err[d];
                    got_n[d] = got_n[d] + 1;
                end
            end
        end
    end

    // ---------------- Stimulus ----------------
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // gnt does not depend on req, so its mid-cycle value decides the next edge.
    task automatic issue(input int d, input logic we, input logic [31:0] addr,
                         input logic [3:0] be, input logic [31:0] wdata, input logic [1:0] aid);
        int unsigned waited;
        waited       = 0;
        drv_req[d]   = 1'b1;
        drv_we[d]    = we;
        drv_addr[d]  = addr;
        drv_be[d]    = be;
        drv_wdata[d] = wdata;
        drv_aid[d]   = aid;
        @(negedge clk_i);
        while (!obs_gnt[d] && waited < 50) begin
            @(negedge clk_i);
            waited++;
        end
        if (!obs_gnt[d]) begin
            chk($sformatf("dut%0d.issue_timeout", d), waited, 32'h0);
            drv_req[d] = 1'b0;
        end else begin
            tick();
        end
    endtask

    task automatic drain(input int d);
        int unsigned waited;
        waited = 0;
        drv_req[d] = 1'b0;
        while (mq_cnt[d] != 0 && waited < 100) begin
            tick();
            waited++;
        end
        tick();
        chk($sformatf("dut%0d.drain_pending", d), mq_cnt[d], 32'h0);
    endtask

    task automatic clear_log(input int d);
        got_n[d]    = 0;
        rv_cnt[d]   = 0;
        rv_first[d] = 0;
        rv_last[d]  = 0;
        gnt_low[d]  = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < NDut; d++) begin
            drv_req[d] = 1'b0; drv_we[d] = 1'b0; drv_addr[d] = '0; drv_be[d] = '0;
            drv_wdata[d] = '0; drv_aid[d] = '0; drv_rready[d] = 1'b1;
            clear_log(d);
        end
        rst_ni = 1'b0;
        repeat (3) tick();
        chk("reset_gnt_a",    {31'h0, obs_gnt[0]},    32'h0);
        chk("reset_rvalid_b", {31'h0, obs_rvalid[1]}, 32'h0);
        rst_ni = 1'b1;
        tick();
        chk("post_reset_gnt_a", {31'h0, obs_gnt[0]}, 32'h1);

        // Test 1: write then read back, two in-order responses
        clear_log(0);
        issue(0, 1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF, 2'd1);
        issue(0, 1'b0, 32'h10, 4'h0, 32'h0, 2'd0);
        drain(0);
        chk("t1_count", got_n[0], 32'd2);
        chk("t1_wr_rid", {30'h0, got_id[0][0]}, 32'h1);
        chk("t1_wr_rdata", got_data[0][0], 32'h0);
        chk("t1_wr_err", {31'h0, got_err[0][0]}, 32'h0);
        chk("t1_rd_rid", {30'h0, got_id[0][1]}, 32'h0);
        chk("t1_rd_rdata", got_data[0][1], 32'hDEAD_BEEF);

        // Test 2: partial byte write
        clear_log(0);
        issue(0, 1'b1, 32'h10, 4'h2, 32'h0000_AA00, 2'd0);
        issue(0, 1'b0, 32'h10, 4'h0, 32'h0, 2'd1);
        drain(0);
        chk("t2_rdata", got_data[0][1], 32'hDEAD_AAEF);

        // Test 4: 8 back-to-back reads at Latency 1
        for (int i = 0; i < 8; i++) issue(0, 1'b1, 32'h100 + 4 * i, 4'hF, 32'h1000_0000 + 32'h111 * i, 2'd0);
        drain(0);
        clear_log(0);
        for (int i = 0; i < 8; i++) issue(0, 1'b0, 32'h100 + 4 * i, 4'h0, 32'h0, 2'(i % 2));
        drain(0);
        chk("t4_rvalid_cycles", rv_cnt[0], 32'd8);
        chk("t4_rvalid_span", rv_last[0] - rv_first[0], 32'd7);
        chk("t4_gnt_low", gnt_low[0], 32'd0);
        for (int i = 0; i < 8; i++) chk($sformatf("t4_rdata%0d", i), got_data[0][i], 32'h1000_0000 + 32'h111 * i);

        // Test 3: Latency 3, depth 3, backpressure
        for (int i = 0; i < 4; i++) issue(1, 1'b1, 32'h8000 + 4 * i, 4'hF, 32'hB0B0_0000 + 32'h1111 * i, 2'd1);
        drain(1);
        clear_log(1);
        drv_rready[1] = 1'b0;
        for (int i = 0; i < 3; i++) issue(1, 1'b0, 32'h8000 + 4 * i, 4'h0, 32'h0, 2'(i));
        chk("t3_gnt_after3", {31'h0, obs_gnt[1]}, 32'h0);
        drv_req[1] = 1'b1; drv_we[1] = 1'b0; drv_addr[1] = 32'h800C; drv_aid[1] = 2'd3;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("t3_gnt_hold%0d", i), {31'h0, obs_gnt[1]}, 32'h0);
        end
        chk("t3_rvalid_held", {31'h0, obs_rvalid[1]}, 32'h1);
        chk("t3_rdata_held", obs_rdata[1], 32'hB0B0_0000);
        drv_rready[1] = 1'b1;
        chk("t3_gnt_popcycle", {31'h0, obs_gnt[1]}, 32'h0);
        tick();
        chk("t3_gnt_after_pop", {31'h0, obs_gnt[1]}, 32'h1);
        tick();
        drv_req[1] = 1'b0;
        drain(1);
        chk("t3_count", got_n[1], 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t3_rdata%0d", i), got_data[1][i], 32'hB0B0_0000 + 32'h1111 * i);
            chk($sformatf("t3_rid%0d", i), {30'h0, got_id[1][i]}, i);
        end

        // Test 5: out-of-range address 0x1000 (idx 1024)
        clear_log(0);
        issue(0, 1'b1, 32'h0, 4'hF, 32'h1234_5678, 2'd0);
        issue(0, 1'b0, 32'h1000, 4'h0, 32'h0, 2'd1);
        issue(0, 1'b1, 32'h1000, 4'hF, 32'hCAFE_F00D, 2'd0);
        issue(0, 1'b0, 32'h0, 4'h0, 32'h0, 2'd1);
        drain(0);
        chk("t5_count", got_n[0], 32'd4);
        chk("t5_oor_rid", {30'h0, got_id[0][1]}, 32'h1);
        if (OorEn) begin
            chk("t5_oor_rdata", got_data[0][1], 32'h0);
            chk("t5_oor_err", {31'h0, got_err[0][1]}, 32'h1);
            chk("t5_oor_wr_err", {31'h0, got_err[0][2]}, 32'h1);
            chk("t5_mem0_untouched", got_data[0][3], 32'h1234_5678);
        end else begin
            chk("t5_alias_rdata", got_data[0][1], 32'h1234_5678);
            chk("t5_alias_err", {31'h0, got_err[0][1]}, 32'h0);
            chk("t5_alias_wr_err", {31'h0, got_err[0][2]}, 32'h0);
            chk("t5_alias_mem0", got_data[0][3], 32'hCAFE_F00D);
        end

        // Test 6: reset with two responses pending
        drv_rready[0] = 1'b0;
        issue(0, 1'b0, 32'h10, 4'h0, 32'h0, 2'd0);
        issue(0, 1'b0, 32'h104, 4'h0, 32'h0, 2'd1);
        drv_req[0] = 1'b0;
        tick();
        chk("t6_pending_rvalid", {31'h0, obs_rvalid[0]}, 32'h1);
        chk("t6_pending_gnt", {31'h0, obs_gnt[0]}, 32'h0);
        rst_ni = 1'b0;
        #1;
        chk("t6_rst_rvalid", {31'h0, obs_rvalid[0]}, 32'h0);
        chk("t6_rst_rdata", obs_rdata[0], 32'h0);
        repeat (2) tick();
        rst_ni = 1'b1;
        drv_rready[0] = 1'b1;
        clear_log(0);
        tick();
        chk("t6_release_gnt", {31'h0, obs_gnt[0]}, 32'h1);
        repeat (5) tick();
        chk("t6_no_stale", rv_cnt[0], 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
